// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Byte-wide RAM port shared between instruction fetch and SLB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              control_hazard,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              slb_req,
    input  logic [ADDR_W-1:0] slb_addr,
    input  logic              slb_wr,
    input  logic [7:0]        slb_dout,
    input  logic              slb_last,
    output logic              slb_grant,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_IFETCH  = 2'd1;
    localparam logic [1:0] c_IF_DONE = 2'd2;
    localparam logic [1:0] c_SLB     = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;
    logic              r_last_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [23:0]       r_cap;

    logic              w_stall;
    logic              w_in_slb;
    logic              w_if_ok;

    // Writes into the I/O window (addr[17:16]==3) must wait for the sink.
    assign w_stall   = slb_wr && (slb_addr[17:16] == 2'b11) && io_buffer_full;
    assign w_in_slb  = (r_state == c_SLB);
    assign w_if_ok   = if_req && !control_hazard;

    assign slb_grant = w_in_slb && rdy_in && slb_req && !w_stall;
    assign mem_wr    = slb_grant && slb_wr;
    assign mem_dout  = w_in_slb ? slb_dout : 8'h00;
    assign if_done   = (r_state == c_IF_DONE) && rdy_in && !control_hazard;
    assign if_inst   = if_done ? {mem_din, r_cap} : 32'h0;

    always_comb begin
        mem_a = '0;
        case (r_state)
            c_IFETCH: mem_a = r_addr + {{(ADDR_W-2){1'b0}}, r_cnt};
            c_SLB:    mem_a = slb_addr;
            default:  mem_a = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= c_IDLE;
            r_cnt        <= 2'd0;
            r_last_owner <= 1'b1;
            r_addr       <= '0;
            r_cap        <= 24'h0;
        end else if (rdy_in) begin
            case (r_state)
                c_IDLE: begin
                    // On a tie the requester that did not go last wins.
                    if (slb_req && (!w_if_ok || !r_last_owner)) begin
                        r_state <= c_SLB;
                    end else if (w_if_ok) begin
                        r_state <= c_IFETCH;
                        r_addr  <= if_addr;
                        r_cnt   <= 2'd0;
                    end
                end
                c_IFETCH: begin
                    if (control_hazard) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 2'd0;
                    end else begin
                        case (r_cnt)
                            2'd1:    r_cap[7:0]   <= mem_din;
                            2'd2:    r_cap[15:8]  <= mem_din;
                            2'd3:    r_cap[23:16] <= mem_din;
                            default: ;
                        endcase
                        if (r_cnt == 2'd3) begin
                            r_state <= c_IF_DONE;
                            r_cnt   <= 2'd0;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                c_IF_DONE: begin
                    r_state <= c_IDLE;
                    if (!control_hazard) begin
                        r_last_owner <= 1'b0;
                    end
                end
                c_SLB: begin
                    if ((slb_grant && slb_last) || !slb_req) begin
                        r_state      <= c_IDLE;
                        r_last_owner <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        control_hazard;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        slb_req;
    logic [31:0] slb_addr;
    logic        slb_wr;
    logic [7:0]  slb_dout;
    logic        slb_last;
    logic        slb_grant;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;

    logic [7:0]  ram [0:1023];
    logic [7:0]  st_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .control_hazard(control_hazard), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .slb_req(slb_req), .slb_addr(slb_addr), .slb_wr(slb_wr),
        .slb_dout(slb_dout), .slb_last(slb_last), .slb_grant(slb_grant),
        .mem_din(mem_din), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout)
    );

    always #5 clk_in = ~clk_in;

    // RAM: preloaded while reset is held, one-cycle read latency.
    always @(posedge clk_in) begin
        if (!rst_in) begin
            ram[10'h100] <= 8'h13;
            ram[10'h101] <= 8'h05;
            ram[10'h102] <= 8'h10;
            ram[10'h103] <= 8'h00;
        end else if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; control_hazard = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; slb_req = 1'b0; slb_addr = 32'h0;
        slb_wr = 1'b0; slb_dout = 8'h00; slb_last = 1'b0;

        repeat (2) tick();
        if_req = 1'b1; if_addr = 32'h100; slb_req = 1'b1; slb_wr = 1'b1; slb_dout = 8'h5A;
        #1;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_if_done", {31'b0, if_done}, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_grant", {31'b0, slb_grant}, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        tick(); rst_in = 1'b1; if_req = 1'b0; slb_req = 1'b0; slb_wr = 1'b0; slb_dout = 8'h00;

        // Tie from reset: IF wins, fetch 0x100.
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        slb_req = 1'b1; slb_wr = 1'b0; slb_addr = 32'h200; slb_last = 1'b1;
        #1; chk("tie0_grant", {31'b0, slb_grant}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("fetch_mem_a", mem_a, 32'h100 + k);
            chk("fetch_grant", {31'b0, slb_grant}, 32'h0);
            chk("fetch_mem_wr", {31'b0, mem_wr}, 32'h0);
            chk("fetch_done_early", {31'b0, if_done}, 32'h0);
        end
        tick(); #1;
        chk("if_done", {31'b0, if_done}, 32'h1);
        chk("if_inst", if_inst, 32'h00100513);
        chk("done_grant", {31'b0, slb_grant}, 32'h0);
        tick(); #1;
        chk("done_pulse", {31'b0, if_done}, 32'h0);
        chk("idle_grant", {31'b0, slb_grant}, 32'h0);
        tick(); #1;
        chk("tie1_slb_grant", {31'b0, slb_grant}, 32'h1);
        chk("tie1_mem_a", mem_a, 32'h200);
        chk("tie1_mem_wr", {31'b0, mem_wr}, 32'h0);
        tick(); #1;
        chk("tie2_idle", {31'b0, slb_grant}, 32'h0);
        tick(); if_req = 1'b0; slb_req = 1'b0; #1;
        chk("tie2_if_wins", mem_a, 32'h100);

        // Flush at cnt=2.
        tick(); #1; chk("hz_cnt1", mem_a, 32'h101);
        tick(); control_hazard = 1'b1; #1; chk("hz_cnt2", mem_a, 32'h102);
        tick(); control_hazard = 1'b0; #1;
        chk("hz_idle", mem_a, 32'h0);
        chk("hz_no_done", {31'b0, if_done}, 32'h0);
        repeat (3) begin
            tick(); #1; chk("hz_no_done_late", {31'b0, if_done}, 32'h0);
        end

        // Flush concurrent with a new request blocks the fetch.
        tick(); if_req = 1'b1; control_hazard = 1'b1; #1;
        tick(); if_req = 1'b0; control_hazard = 1'b0; #1;
        chk("hz_blocks_if", mem_a, 32'h0);

        // Four-byte store.
        tick(); slb_req = 1'b1; slb_wr = 1'b1; slb_last = 1'b0;
        slb_addr = 32'h200; slb_dout = st_bytes[0]; #1;
        chk("st_idle_grant", {31'b0, slb_grant}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            slb_addr = 32'h200 + i; slb_dout = st_bytes[i]; slb_last = (i == 3);
            #1;
            chk("st_grant", {31'b0, slb_grant}, 32'h1);
            chk("st_mem_wr", {31'b0, mem_wr}, 32'h1);
            chk("st_mem_a", mem_a, 32'h200 + i);
            chk("st_mem_dout", {24'b0, mem_dout}, {24'b0, st_bytes[i]});
        end
        tick(); slb_req = 1'b0; slb_last = 1'b0; #1;
        chk("st_end_grant", {31'b0, slb_grant}, 32'h0);
        chk("st_end_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("st_ram0", {24'b0, ram[10'h200]}, 32'hAA);
        chk("st_ram3", {24'b0, ram[10'h203]}, 32'hDD);

        // I/O write stalled three cycles.
        tick(); slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h30000;
        slb_dout = 8'h55; slb_last = 1'b1; io_buffer_full = 1'b1; #1;
        repeat (3) begin
            tick(); #1;
            chk("io_stall_grant", {31'b0, slb_grant}, 32'h0);
            chk("io_stall_wr", {31'b0, mem_wr}, 32'h0);
        end
        tick(); io_buffer_full = 1'b0; #1;
        chk("io_grant", {31'b0, slb_grant}, 32'h1);
        chk("io_mem_wr", {31'b0, mem_wr}, 32'h1);
        chk("io_mem_a", mem_a, 32'h30000);
        tick(); slb_req = 1'b0; slb_last = 1'b0; #1;
        chk("io_end", {31'b0, slb_grant}, 32'h0);

        // rdy_in freeze, then reset during the first of two bytes.
        tick(); slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h210;
        slb_dout = 8'h11; slb_last = 1'b0; #1;
        tick(); rdy_in = 1'b0; #1;
        chk("rdy_grant", {31'b0, slb_grant}, 32'h0);
        chk("rdy_mem_wr", {31'b0, mem_wr}, 32'h0);
        tick(); rdy_in = 1'b1; #1;
        chk("b1_grant", {31'b0, slb_grant}, 32'h1);
        rst_in = 1'b0; #1;
        chk("mid_rst_grant", {31'b0, slb_grant}, 32'h0);
        chk("mid_rst_wr", {31'b0, mem_wr}, 32'h0);
        chk("mid_rst_mem_a", mem_a, 32'h0);
        chk("mid_rst_dout", {24'b0, mem_dout}, 32'h0);
        tick(); rst_in = 1'b1; slb_req = 1'b0; #1;
        chk("post_rst_grant", {31'b0, slb_grant}, 32'h0);
        tick(); #1;
        chk("post_rst_idle", mem_a, 32'h0);
        tick(); slb_req = 1'b1; slb_last = 1'b1; #1;
        chk("new_req_idle", {31'b0, slb_grant}, 32'h0);
        tick(); #1;
        chk("new_req_grant", {31'b0, slb_grant}, 32'h1);
        tick(); slb_req = 1'b0; slb_last = 1'b0; #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
